sha256_msg_padder: RTL and testbench



---
 rtl/sha256_pkg.sv | 50 +++++
 rtl/sha256_msg_padder_if.sv | 33 +++
 rtl/sha256_pad_word.sv | 29 ++
 rtl/sha256_msg_padder.sv | 185 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
// Shared constants and types for the SHA-256 message padder and the chained
// SHA-256 core: block/word geometry, padding constants, the padder state
// enum, and the standard H0-H7 initial hash and K round constants.
// ----------------------------------------------------------------------------
package sha256_pkg;

    localparam int WORD_W             = 32;
    localparam int BLOCK_W            = 512;
    localparam int WORDS_PER_BLOCK    = 16;
    localparam int LEN_FIELD_W        = 64;
    localparam int MAX_ONEBLOCK_BYTES = 55;

    localparam logic [7:0]        PAD_BYTE = 8'h80;
    // Padding marker sitting alone at the start of a word.
    localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, 24'h000000};

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pad_state_e;

    // Initial hash value, H0 in the most significant word.
    localparam logic [7:0][WORD_W-1:0] SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants, K[0] in the most significant word.
    localparam logic [63:0][WORD_W-1:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_msg_padder_if.sv
// ----------------------------------------------------------------------------
// sha256_msg_padder_if
// Bundles the padder's two handshakes:
//   s_*  word stream in  (s_valid/s_ready, s_data, s_last, s_bytes)
//   m_*  block stream out (m_valid/m_ready, m_block, m_first, m_last)
// Modport slave is the padder's view; master is the feeder/sink view.
// ----------------------------------------------------------------------------
interface sha256_msg_padder_if;
    import sha256_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [WORD_W-1:0]  s_data;
    logic               s_last;
    logic [2:0]         s_bytes;

    logic               m_valid;
    logic               m_ready;
    logic [BLOCK_W-1:0] m_block;
    logic               m_first;
    logic               m_last;

    modport slave (
        input  s_valid, s_data, s_last, s_bytes, m_ready,
        output s_ready, m_valid, m_block, m_first, m_last
    );

    modport master (
        output s_valid, s_data, s_last, s_bytes, m_ready,
        input  s_ready, m_valid, m_block, m_first, m_last
    );

endinterface

// File: rtl/sha256_pad_word.sv
// ----------------------------------------------------------------------------
// sha256_pad_word
// Combinational masking of one big-endian message word.
//   i_word        word as received, byte 0 in [31:24]
//   i_nbytes      number of leading bytes to keep (values >= 4 keep all)
//   i_insert_pad  place 0x80 at byte i_nbytes when it falls inside the word
//   o_word        kept bytes, optional 0x80, zeros elsewhere
// ----------------------------------------------------------------------------
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [2:0]        i_nbytes,
    input  logic              i_insert_pad,
    output logic [WORD_W-1:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < i_nbytes) begin
                o_word[WORD_W-1-8*k -: 8] = i_word[WORD_W-1-8*k -: 8];
            end else if ((3'(k) == i_nbytes) && i_insert_pad) begin
                o_word[WORD_W-1-8*k -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// ----------------------------------------------------------------------------
// sha256_msg_padder
// Turns a byte message, delivered as 32-bit big-endian words, into SHA-256
// padded 512-bit blocks (0x80, zero fill, 64-bit bit length) on a
// valid/ready handshake with first/last-of-message flags.
//   clk, rst  clock; synchronous active-high reset
//   bus       sha256_msg_padder_if.slave: s_* word input, m_* block output
// Words are collected in FILL; a completed block is held in EMIT until taken.
// When the padding tail does not fit, a second (extra) block carrying the
// length is emitted straight after the data block.
// ----------------------------------------------------------------------------
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_BYTES_W = 61
) (
    input  logic                 clk,
    input  logic                 rst,
    sha256_msg_padder_if.slave   bus
);

    pad_state_e r_state;
    pad_state_e w_state_nxt;

    logic [0:WORDS_PER_BLOCK-1][WORD_W-1:0] r_buf;
    logic [3:0]                             r_word_idx;
    logic [LEN_BYTES_W-1:0]                 r_byte_cnt;
    logic                                   r_first_pending;
    logic                                   r_extra_pending;
    logic                                   r_extra_pad;
    logic [LEN_FIELD_W-1:0]                 r_len;

    logic [BLOCK_W-1:0] r_m_block;
    logic               r_m_valid;
    logic               r_m_first;
    logic               r_m_last;

    logic                                   w_s_ready;
    logic                                   w_s_hs;
    logic                                   w_m_hs;
    logic                                   w_block_done;
    logic [2:0]                             w_nb;
    logic [6:0]                             w_b;
    logic [LEN_BYTES_W-1:0]                 w_cnt_nxt;
    logic [LEN_FIELD_W-1:0]                 w_len;
    logic                                   w_len_in_block;
    logic                                   w_pad_spill;
    logic [WORD_W-1:0]                      w_pad_word;
    logic [0:WORDS_PER_BLOCK-1][WORD_W-1:0] w_cap_words;
    logic [0:WORDS_PER_BLOCK-1][WORD_W-1:0] w_extra_words;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        case (r_state)
            FILL: begin
                w_s_ready = !rst;
                if (bus.s_valid && (bus.s_last || (r_word_idx == 4'd15)))
                    w_state_nxt = EMIT;
            end
            EMIT: begin
                // Stay in EMIT across the data->extra block hand-over.
                if (w_m_hs && !r_extra_pending)
                    w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    assign w_s_hs       = bus.s_valid && w_s_ready;
    assign w_m_hs       = r_m_valid && bus.m_ready;
    assign w_block_done = bus.s_last || (r_word_idx == 4'd15);

    // ------------------------------------------------------------------
    // Padding arithmetic for the beat being offered
    // ------------------------------------------------------------------
    // Out-of-range byte counts collapse to a full word; non-last beats are
    // always full words.
    assign w_nb      = !bus.s_last            ? 3'd4 :
                       (bus.s_bytes > 3'd4)   ? 3'd4 : bus.s_bytes;
    // Message bytes occupied in the current block, 0..64.
    assign w_b       = {1'b0, r_word_idx, 2'b00} + {4'b0000, w_nb};
    assign w_cnt_nxt = r_byte_cnt + LEN_BYTES_W'(w_nb);
    assign w_len     = LEN_FIELD_W'({w_cnt_nxt, 3'b000});

    assign w_len_in_block = bus.s_last && (w_b <= 7'(MAX_ONEBLOCK_BYTES));
    // A full last word pushes 0x80 into the following word (if any).
    assign w_pad_spill    = bus.s_last && (w_nb == 3'd4);

    sha256_pad_word u_pad_word (
        .i_word       (bus.s_data),
        .i_nbytes     (w_nb),
        .i_insert_pad (bus.s_last),
        .o_word       (w_pad_word)
    );

    // Per-word assembly of the block captured on the closing beat and of
    // the length-only extra block. Lanes below word_idx are buffered data,
    // the lane at word_idx is the incoming word, everything beyond is pad.
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_lane
        localparam logic [3:0] LANE = 4'(gi);
        logic [WORD_W-1:0] w_len_word;

        assign w_len_word = (gi == WORDS_PER_BLOCK-2) ? r_len[63:32] : r_len[31:0];

        assign w_cap_words[gi] =
            (w_len_in_block && gi >= WORDS_PER_BLOCK-2) ?
                ((gi == WORDS_PER_BLOCK-2) ? w_len[63:32] : w_len[31:0]) :
            (LANE < r_word_idx)                           ? r_buf[gi]    :
            (LANE == r_word_idx)                          ? w_pad_word   :
            (w_pad_spill && LANE == r_word_idx + 4'd1)    ? PAD_WORD     :
                                                            '0;

        assign w_extra_words[gi] =
            (gi >= WORDS_PER_BLOCK-2)   ? w_len_word :
            (gi == 0 && r_extra_pad)    ? PAD_WORD   :
                                          '0;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf           <= '0;
            r_word_idx      <= '0;
            r_byte_cnt      <= '0;
            r_first_pending <= 1'b1;
            r_extra_pending <= 1'b0;
            r_extra_pad     <= 1'b0;
            r_len           <= '0;
            r_m_block       <= '0;
            r_m_valid       <= 1'b0;
            r_m_first       <= 1'b0;
            r_m_last        <= 1'b0;
        end else begin
            if (w_s_hs) begin
                r_buf[r_word_idx] <= bus.s_data;
                r_word_idx        <= r_word_idx + 4'd1;
                r_byte_cnt        <= w_cnt_nxt;
                if (w_block_done) begin
                    r_m_valid       <= 1'b1;
                    r_m_block       <= w_cap_words;
                    r_m_first       <= r_first_pending;
                    r_m_last        <= w_len_in_block;
                    r_extra_pending <= bus.s_last && !w_len_in_block;
                    r_extra_pad     <= (w_b == 7'd64);
                    r_len           <= w_len;
                end
            end

            if (w_m_hs) begin
                r_first_pending <= 1'b0;
                if (r_extra_pending) begin
                    r_m_block       <= w_extra_words;
                    r_m_first       <= 1'b0;
                    r_m_last        <= 1'b1;
                    r_extra_pending <= 1'b0;
                end else begin
                    r_m_valid  <= 1'b0;
                    r_word_idx <= '0;
                    if (r_m_last) begin
                        r_byte_cnt      <= '0;
                        r_first_pending <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_block = r_m_block;
    assign bus.m_first = r_m_first;
    assign bus.m_last  = r_m_last;

endmodule

// File: tb/tb_sha256_msg_padder.sv
module tb_sha256_msg_padder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_BYTES_W(61)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Messages queued for the next stream: concatenated bytes, lengths,
    // and whether a full-word message ends with an extra 0-byte last beat.
    byte unsigned g_bytes[$];
    int           g_lens[$];
    bit           g_zb[$];

    logic [511:0] exp_blk[$];
    bit           exp_first[$];
    bit           exp_last[$];
    logic [511:0] got_blk[$];
    bit           got_first[$];
    bit           got_last[$];
    int           got_cyc[$];

    logic [31:0]  w_data[$];
    bit           w_last[$];
    logic [2:0]   w_bytes[$];

    task automatic clear_msgs();
        g_bytes.delete(); g_lens.delete(); g_zb.delete();
    endtask

    task automatic add_msg(input int len, input bit zb, input bit seq);
        for (int i = 0; i < len; i++) g_bytes.push_back(seq ? 8'(i) : 8'($urandom));
        g_lens.push_back(len);
        g_zb.push_back(zb && len > 0 && (len % 4) == 0);
    endtask

    // Reference: textbook SHA-256 padding over the whole byte string.
    task automatic build_ref();
        int pos;
        byte unsigned p[$];
        longint unsigned bl;
        int nb;
        logic [511:0] blk;
        pos = 0;
        exp_blk.delete(); exp_first.delete(); exp_last.delete();
        foreach (g_lens[m]) begin
            p.delete();
            for (int i = 0; i < g_lens[m]; i++) p.push_back(g_bytes[pos+i]);
            pos += g_lens[m];
            bl = longint'(g_lens[m]) * 8;
            p.push_back(8'h80);
            while ((p.size() % 64) != 56) p.push_back(8'h00);
            for (int i = 7; i >= 0; i--) p.push_back(8'(bl >> (8*i)));
            nb = p.size() / 64;
            for (int b = 0; b < nb; b++) begin
                blk = '0;
                for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
                exp_blk.push_back(blk);
                exp_first.push_back(b == 0);
                exp_last.push_back(b == nb-1);
            end
        end
    endtask

    // Word stream with random junk beyond the valid bytes and on s_bytes
    // of non-last beats.
    task automatic build_words();
        int pos, n, rem, nw;
        logic [31:0] wd;
        pos = 0;
        w_data.delete(); w_last.delete(); w_bytes.delete();
        foreach (g_lens[m]) begin
            n = g_lens[m]; rem = n % 4; nw = (n + 3) / 4;
            for (int k = 0; k < nw; k++) begin
                for (int j = 0; j < 4; j++)
                    wd[31-8*j -: 8] = (4*k+j < n) ? g_bytes[pos+4*k+j] : 8'($urandom);
                w_data.push_back(wd);
                if (k == nw-1 && !g_zb[m]) begin
                    w_last.push_back(1'b1);
                    w_bytes.push_back(rem != 0 ? 3'(rem) : 3'($urandom_range(4, 7)));
                end else begin
                    w_last.push_back(1'b0);
                    w_bytes.push_back(3'($urandom_range(0, 7)));
                end
            end
            if (n == 0 || g_zb[m]) begin
                w_data.push_back($urandom); w_last.push_back(1'b1); w_bytes.push_back(3'd0);
            end
            pos += n;
        end
    endtask

    task automatic run_stream(input string name, input int stall, input int rdy_pct, input int gap_pct);
        int wi, cyc, widx, stall_left, nexp;
        bit lat_chk, stalling;
        logic [511:0] held_blk;
        bit held_f, held_l;
        build_ref(); build_words();
        got_blk.delete(); got_first.delete(); got_last.delete(); got_cyc.delete();
        nexp = exp_blk.size();
        wi = 0; cyc = 0; widx = 0; stall_left = stall; lat_chk = 0; stalling = 0;
        held_blk = '0; held_f = 0; held_l = 0;
        while (got_blk.size() < nexp && cyc < 20000) begin
            @(negedge clk);
            if (lat_chk) begin
                n_vec++;
                if (bus.m_valid !== 1'b1) begin
                    n_err++; $display("FAIL %s latency: m_valid=%b required 1", name, bus.m_valid);
                end
                lat_chk = 0;
            end
            if (bus.m_valid && stall_left > 0) begin
                if (stalling) begin
                    n_vec++;
                    if (bus.m_block !== held_blk || bus.m_first !== held_f || bus.m_last !== held_l) begin
                        n_err++; $display("FAIL %s stall_hold: block/first/last changed (%b/%b vs %b/%b)",
                                          name, bus.m_first, bus.m_last, held_f, held_l);
                    end
                end else begin
                    held_blk = bus.m_block; held_f = bus.m_first; held_l = bus.m_last; stalling = 1;
                end
                bus.m_ready = 1'b0;
                stall_left--;
            end else begin
                bus.m_ready = ($urandom_range(99) < rdy_pct);
            end
            if (wi < w_data.size()) begin
                bus.s_valid = ($urandom_range(99) >= gap_pct);
                bus.s_data  = w_data[wi];
                bus.s_last  = w_last[wi];
                bus.s_bytes = w_bytes[wi];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
                bus.s_last  = 1'($urandom);
                bus.s_bytes = 3'($urandom);
            end
            #1;
            if (bus.m_valid) begin
                n_vec++;
                if (bus.s_ready !== 1'b0) begin
                    n_err++; $display("FAIL %s s_ready_while_held: s_ready=%b required 0", name, bus.s_ready);
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                if (w_last[wi] || widx == 15) begin lat_chk = 1; widx = 0; end
                else widx++;
                wi++;
            end
            if (bus.m_valid && bus.m_ready) begin
                got_blk.push_back(bus.m_block);
                got_first.push_back(bus.m_first);
                got_last.push_back(bus.m_last);
                got_cyc.push_back(cyc);
            end
            cyc++;
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        n_vec++;
        if (got_blk.size() != nexp) begin
            n_err++; $display("FAIL %s block_count: got %0d required %0d (cycles %0d)", name, got_blk.size(), nexp, cyc);
        end
        for (int i = 0; i < got_blk.size() && i < nexp; i++) begin
            n_vec++;
            if (got_blk[i] !== exp_blk[i]) begin
                n_err++; $display("FAIL %s block[%0d]: got %h required %h", name, i, got_blk[i], exp_blk[i]);
            end
            n_vec++;
            if (got_first[i] !== exp_first[i] || got_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL %s flags[%0d]: first/last got %b/%b required %b/%b",
                                  name, i, got_first[i], got_last[i], exp_first[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_first !== 1'b0 || bus.m_last !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: s_ready/m_valid/first/last got %b%b%b%b required 0000",
                              bus.s_ready, bus.m_valid, bus.m_first, bus.m_last);
        end
        n_vec++;
        if (bus.m_block !== 512'h0) begin
            n_err++; $display("FAIL reset_block: got %h required 0", bus.m_block);
        end
        @(negedge clk); rst = 1'b0; #1;
        n_vec++;
        if (bus.s_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release: s_ready got %b required 1", bus.s_ready);
        end
    endtask

    task automatic check_abc(input string name);
        n_vec++;
        if (got_blk.size() < 1 || got_blk[0] !== {32'h61626380, 448'h0, 32'h00000018}) begin
            n_err++; $display("FAIL %s abc_const: got %0d blocks, block0 %h", name, got_blk.size(),
                              got_blk.size() > 0 ? got_blk[0] : 512'h0);
        end
    endtask

    task automatic add_abc();
        g_bytes.push_back(8'h61); g_bytes.push_back(8'h62); g_bytes.push_back(8'h63);
        g_lens.push_back(3); g_zb.push_back(1'b0);
    endtask

    task automatic test_abc();
        clear_msgs(); add_abc();
        run_stream("abc", 0, 100, 0);
        check_abc("abc");
    endtask

    task automatic test_empty();
        clear_msgs(); add_msg(0, 0, 0);
        run_stream("empty", 0, 100, 0);
        n_vec++;
        if (got_blk.size() < 1 || got_blk[0] !== {32'h80000000, 480'h0}) begin
            n_err++; $display("FAIL empty_const: got %0d blocks", got_blk.size());
        end
    endtask

    task automatic test_56();
        clear_msgs(); add_msg(56, 0, 1);
        run_stream("len56", 0, 100, 20);
        n_vec++;
        if (got_blk.size() != 2 || got_blk[0][63:0] !== 64'h80000000_00000000 ||
            got_blk[1] !== {480'h0, 32'h000001C0}) begin
            n_err++; $display("FAIL len56_const: got %0d blocks, tail0 %h", got_blk.size(),
                              got_blk.size() > 0 ? got_blk[0][63:0] : 64'h0);
        end
    endtask

    task automatic test_1k();
        clear_msgs(); add_msg(1024, 0, 0);
        run_stream("len1024", 0, 80, 10);
        n_vec++;
        if (got_blk.size() != 17 || got_blk[16] !== {32'h80000000, 448'h0, 32'h00002000}) begin
            n_err++; $display("FAIL len1024_const: got %0d blocks required 17", got_blk.size());
        end
    endtask

    // Stall block 1 of a two-block message while the next message's word
    // is already offered.
    task automatic test_backpressure();
        clear_msgs(); add_msg(60, 0, 0); add_abc();
        run_stream("backpressure", 10, 100, 0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1; bus.s_data = $urandom; bus.s_last = 1'b0; bus.s_bytes = 3'd4;
            #1;
            n_vec++;
            if (bus.s_ready !== 1'b1) begin
                n_err++; $display("FAIL reset_mid_accept: s_ready got %b required 1", bus.s_ready);
            end
        end
        @(negedge clk); bus.s_valid = 1'b0; rst = 1'b1; #1;
        n_vec++;
        if (bus.s_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_sready: got %b required 0", bus.s_ready);
        end
        @(negedge clk); rst = 1'b0;
        clear_msgs(); add_abc();
        run_stream("reset_mid", 0, 100, 0);
        check_abc("reset_mid");
        n_vec++;
        if (got_first.size() < 1 || got_first[0] !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_first: m_first not 1");
        end
    endtask

    task automatic test_reset_emit();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.s_valid = 1'b1; bus.s_data = $urandom; bus.s_last = 1'b0;
        end
        @(negedge clk); bus.s_valid = 1'b0; #1;
        n_vec++;
        if (bus.m_valid !== 1'b1) begin
            n_err++; $display("FAIL reset_emit_valid: got %b required 1", bus.m_valid);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.m_block !== 512'h0) begin
            n_err++; $display("FAIL reset_emit_clear: m_valid %b block %h", bus.m_valid, bus.m_block);
        end
        rst = 1'b0;
        clear_msgs(); add_abc();
        run_stream("reset_emit", 0, 100, 0);
        check_abc("reset_emit");
    endtask

    // 192 bytes with no gaps: three full data blocks 17 cycles apart, then
    // the 0x80+length block in the very next cycle.
    task automatic test_back_to_back();
        clear_msgs(); add_msg(192, 0, 0);
        run_stream("throughput", 0, 100, 0);
        n_vec++;
        if (got_cyc.size() != 4 || got_cyc[1] - got_cyc[0] != 17 || got_cyc[2] - got_cyc[1] != 17 ||
            got_cyc[3] - got_cyc[2] != 1) begin
            n_err++; $display("FAIL throughput_spacing: %0d blocks, spacing %0d/%0d/%0d required 17/17/1",
                              got_cyc.size(),
                              got_cyc.size() > 1 ? got_cyc[1] - got_cyc[0] : -1,
                              got_cyc.size() > 2 ? got_cyc[2] - got_cyc[1] : -1,
                              got_cyc.size() > 3 ? got_cyc[3] - got_cyc[2] : -1);
        end
        clear_msgs();
        add_msg(55, 0, 0); add_msg(56, 1, 0); add_msg(63, 0, 0);
        add_msg(64, 0, 0); add_msg(0, 0, 0);  add_msg(64, 1, 0); add_msg(4, 0, 0);
        run_stream("back_to_back", 0, 100, 0);
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 4; r++) begin
            clear_msgs();
            for (int m = 0; m < 6; m++) begin
                len = ($urandom_range(1) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(50, 70));
                add_msg(len, 1'($urandom), 0);
            end
            run_stream("random", $urandom_range(0, 5), 60, 30);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.s_bytes = '0; bus.m_ready = 1'b0;
        test_reset();
        test_abc();
        test_empty();
        test_56();
        test_1k();
        test_backpressure();
        test_reset_mid();
        test_reset_emit();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
